// File: rtl/snake_pkg.sv
// Shared encodings for the snake body engine: directions, MSM states, colours, FSM states.
// No datapath, so it has no latency and no backpressure.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_LEFT  = 2'b01,
      DIR_RIGHT = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      MSM_IDLE = 2'b00,
      MSM_PLAY = 2'b01,
      MSM_WIN  = 2'b10,
      MSM_LOSE = 2'b11
   } msm_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DEAD = 2'b10
   } state_e;

   localparam logic [11:0] COL_HEAD = 12'hF00;
   localparam logic [11:0] COL_BODY = 12'h0F0;
   localparam logic [11:0] COL_TGT  = 12'h00F;
   localparam logic [11:0] COL_BG   = 12'h000;

   // The encoding puts each direction's reverse at its bitwise complement.
   function automatic logic [1:0] opposite(input logic [1:0] d);
      return ~d;
   endfunction

endpackage

// File: rtl/snake_seg_match.sv
// N-way coordinate comparator: hit when any entry below len_i equals (x_i, y_i).
// Purely combinational (0 cycles); no backpressure.
module snake_seg_match
   import snake_pkg::*;
#(
   parameter int unsigned N  = 32,
   parameter int unsigned XW = 8,
   parameter int unsigned YW = 7,
   parameter int unsigned LW = $clog2(N + 1)
) (
   input  logic [XW-1:0] seg_x_i [N],
   input  logic [YW-1:0] seg_y_i [N],
   input  logic [XW-1:0] x_i,
   input  logic [YW-1:0] y_i,
   input  logic [LW-1:0] len_i,
   output logic          hit_o
);

   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if ((LW'(i) < len_i) && (seg_x_i[i] == x_i) && (seg_y_i[i] == y_i)) begin
            hit_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/snake_body_engine.sv
// Snake segment chain: moves per tick with wrap, grows on capture, flags self-collision, renders pixels.
// Pulses appear 1 cycle after TICK; COLOUR has 1-cycle latency; no backpressure (TICK is a strobe).
module snake_body_engine
   import snake_pkg::*;
#(
   parameter int unsigned MAX_LEN  = 32,
   parameter int unsigned INIT_LEN = 4,
   parameter int unsigned XW       = 8,
   parameter int unsigned YW       = 7,
   parameter int unsigned MAX_X    = 159,
   parameter int unsigned MAX_Y    = 119,
   parameter int unsigned START_X  = 80,
   parameter int unsigned START_Y  = 100,
   parameter logic [11:0] C_HEAD   = COL_HEAD,
   parameter logic [11:0] C_BODY   = COL_BODY,
   parameter logic [11:0] C_TGT    = COL_TGT,
   parameter logic [11:0] C_BG     = COL_BG,
   parameter int unsigned LW       = $clog2(MAX_LEN + 1)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          tick_i,
   input  logic [1:0]    direction_i,
   input  logic [1:0]    msm_state_i,
   input  logic [XW-1:0] pixel_x_i,
   input  logic [YW-1:0] pixel_y_i,
   input  logic [XW-1:0] target_x_i,
   input  logic [YW-1:0] target_y_i,
   output logic [11:0]   colour_o,
   output logic          reached_target_o,
   output logic          collision_o,
   output logic [LW-1:0] length_o,
   output logic          full_o
);

   logic [XW-1:0] seg_x [MAX_LEN];
   logic [YW-1:0] seg_y [MAX_LEN];

   state_e        state_q, state_d;
   logic [1:0]    heading_q, heading_d;
   logic [LW-1:0] len_q, len_d;
   logic [11:0]   colour_q, colour_d;
   logic          reached_q, collision_q;

   logic          move, restart, capture, hit_col, hit_body, hit_head, full;
   logic [1:0]    dir_eff;
   logic [XW-1:0] nh_x;
   logic [YW-1:0] nh_y;

   assign move    = tick_i && (state_q == ST_RUN);
   assign restart = (state_q == ST_DEAD) && (msm_state_i == MSM_IDLE);
   assign full    = (len_q == LW'(MAX_LEN));
   assign dir_eff = (direction_i == opposite(heading_q)) ? heading_q : direction_i;

   always_comb begin
      nh_x = seg_x[0];
      nh_y = seg_y[0];
      case (dir_eff)
         DIR_UP:   nh_y = (seg_y[0] == '0) ? YW'(MAX_Y) : seg_y[0] - 1'b1;
         DIR_DOWN: nh_y = (seg_y[0] == YW'(MAX_Y)) ? '0 : seg_y[0] + 1'b1;
         DIR_LEFT: nh_x = (seg_x[0] == '0) ? XW'(MAX_X) : seg_x[0] - 1'b1;
         default:  nh_x = (seg_x[0] == XW'(MAX_X)) ? '0 : seg_x[0] + 1'b1;
      endcase
   end

   assign capture = (nh_x == target_x_i) && (nh_y == target_y_i);

   // Cells 0..LENGTH-2 are the ones that become body 1..LENGTH-1 after the shift.
   snake_seg_match #(.N(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) u_col_match (
      .seg_x_i (seg_x),
      .seg_y_i (seg_y),
      .x_i     (nh_x),
      .y_i     (nh_y),
      .len_i   (len_q - LW'(1)),
      .hit_o   (hit_col)
   );

   snake_seg_match #(.N(MAX_LEN), .XW(XW), .YW(YW), .LW(LW)) u_pix_match (
      .seg_x_i (seg_x),
      .seg_y_i (seg_y),
      .x_i     (pixel_x_i),
      .y_i     (pixel_y_i),
      .len_i   (len_q),
      .hit_o   (hit_body)
   );

   for (genvar g = 0; g < MAX_LEN; g++) begin : g_seg
      logic [XW-1:0] x_q, x_d;
      logic [YW-1:0] y_q, y_d;
      if (g == 0) begin : g_head
         assign x_d = nh_x;
         assign y_d = nh_y;
      end else begin : g_body
         assign x_d = seg_x[g-1];
         assign y_d = seg_y[g-1];
      end
      always_ff @(posedge clk_i) begin
         if (reset_i || restart) begin
            x_q <= XW'(START_X);
            y_q <= YW'(START_Y);
         end else if (move) begin
            x_q <= x_d;
            y_q <= y_d;
         end
      end
      assign seg_x[g] = x_q;
      assign seg_y[g] = y_q;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (msm_state_i == MSM_PLAY) state_d = ST_RUN;
         ST_RUN: begin
            if (move && hit_col)               state_d = ST_DEAD;
            else if (msm_state_i != MSM_PLAY) state_d = ST_IDLE;
         end
         ST_DEAD: if (msm_state_i == MSM_IDLE) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      heading_d = heading_q;
      len_d     = len_q;
      if (move) heading_d = dir_eff;
      if (restart) begin
         len_d = LW'(INIT_LEN);
      end else if (move && capture && !hit_col && !full) begin
         len_d = len_q + LW'(1);
      end
   end

   assign hit_head = (pixel_x_i == seg_x[0]) && (pixel_y_i == seg_y[0]);

   always_comb begin
      colour_d = C_BG;
      if (hit_head)                                             colour_d = C_HEAD;
      else if (hit_body)                                        colour_d = C_BODY;
      else if ((pixel_x_i == target_x_i) && (pixel_y_i == target_y_i)) colour_d = C_TGT;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         heading_q   <= DIR_RIGHT;
         len_q       <= LW'(INIT_LEN);
         colour_q    <= C_BG;
         reached_q   <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         heading_q   <= heading_d;
         len_q       <= len_d;
         colour_q    <= colour_d;
         reached_q   <= move && capture && !hit_col;
         collision_q <= move && hit_col;
      end
   end

   assign colour_o         = colour_q;
   assign reached_target_o = reached_q;
   assign collision_o      = collision_q;
   assign length_o         = len_q;
   assign full_o           = full;

endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: movement, wrap, capture, collision, saturation, rendering.
module tb_snake_body_engine;
   import snake_pkg::*;

   logic       clk = 1'b0;
   logic       reset, tick;
   logic [1:0] direction, msm_state;
   logic [7:0] pixel_x, target_x;
   logic [6:0] pixel_y, target_y;
   logic [11:0] colour;
   logic       reached, collision, full;
   logic [5:0] length;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string       tag;
      logic [11:0] col;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   snake_body_engine dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .tick_i           (tick),
      .direction_i      (direction),
      .msm_state_i      (msm_state),
      .pixel_x_i        (pixel_x),
      .pixel_y_i        (pixel_y),
      .target_x_i       (target_x),
      .target_y_i       (target_y),
      .colour_o         (colour),
      .reached_target_o (reached),
      .collision_o      (collision),
      .length_o         (length),
      .full_o           (full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_tick(input logic [1:0] d);
      direction = d;
      tick      = 1'b1;
      step();
      tick      = 1'b0;
   endtask

   task automatic pix(input string tag, input logic [7:0] x, input logic [6:0] y,
                      input logic [11:0] col);
      exp_t e;
      pixel_x = x;
      pixel_y = y;
      sb.push_back('{tag, col});
      step();
      e = sb.pop_front();
      chk(e.tag, {20'd0, colour}, {20'd0, e.col});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; tick = 1'b0; direction = DIR_RIGHT; msm_state = MSM_IDLE;
      pixel_x = 8'd0; pixel_y = 7'd0; target_x = 8'd200; target_y = 7'd0;
      step(); step();
      chk("rst_colour", {20'd0, colour}, {20'd0, COL_BG});
      chk("rst_len", {26'd0, length}, 32'd4);
      chk("rst_reached", {31'd0, reached}, 32'd0);
      chk("rst_collision", {31'd0, collision}, 32'd0);
      chk("rst_full", {31'd0, full}, 32'd0);
      reset = 1'b0;

      // Start play and move three cells right
      msm_state = MSM_PLAY;
      step();
      for (int i = 0; i < 3; i++) begin
         do_tick(DIR_RIGHT);
         chk("mv_reached", {31'd0, reached}, 32'd0);
         chk("mv_collision", {31'd0, collision}, 32'd0);
         step();
      end
      chk("mv_len", {26'd0, length}, 32'd4);
      pix("mv_head", 8'd83, 7'd100, COL_HEAD);
      pix("mv_tail", 8'd80, 7'd100, COL_BODY);
      pix("mv_ahead", 8'd84, 7'd100, COL_BG);
      pix("mv_behind", 8'd79, 7'd100, COL_BG);

      // Right edge wrap
      for (int i = 0; i < 76; i++) begin
         do_tick(DIR_RIGHT);
         step();
      end
      pix("x_edge_head", 8'd159, 7'd100, COL_HEAD);
      do_tick(DIR_RIGHT);
      pix("x_wrap_head", 8'd0, 7'd100, COL_HEAD);
      pix("x_wrap_body", 8'd159, 7'd100, COL_BODY);
      pix("beyond_len", 8'd156, 7'd100, COL_BG);

      // Bottom wrap, then top wrap
      for (int i = 0; i < 20; i++) begin
         do_tick(DIR_DOWN);
         step();
      end
      pix("y_wrap_dn_head", 8'd0, 7'd0, COL_HEAD);
      pix("y_wrap_dn_body", 8'd0, 7'd119, COL_BODY);
      do_tick(DIR_RIGHT);
      do_tick(DIR_UP);
      pix("y_wrap_up_head", 8'd1, 7'd119, COL_HEAD);

      // Capture one cell ahead
      do_tick(DIR_RIGHT);
      target_x = 8'd3; target_y = 7'd119;
      do_tick(DIR_RIGHT);
      chk("cap_pulse", {31'd0, reached}, 32'd1);
      chk("cap_len", {26'd0, length}, 32'd5);
      step();
      chk("cap_pulse_end", {31'd0, reached}, 32'd0);
      pix("head_over_tgt", 8'd3, 7'd119, COL_HEAD);

      // Self-collision with a capture on the same cell
      do_tick(DIR_UP);
      do_tick(DIR_LEFT);
      target_x = 8'd2; target_y = 7'd119;
      do_tick(DIR_DOWN);
      chk("col_pulse", {31'd0, collision}, 32'd1);
      chk("col_no_reach", {31'd0, reached}, 32'd0);
      chk("col_no_grow", {26'd0, length}, 32'd5);
      target_x = 8'd200; target_y = 7'd0;
      step();
      chk("col_pulse_end", {31'd0, collision}, 32'd0);
      pix("col_head", 8'd2, 7'd119, COL_HEAD);
      do_tick(DIR_DOWN);
      chk("dead_no_col", {31'd0, collision}, 32'd0);
      pix("dead_frozen", 8'd2, 7'd119, COL_HEAD);
      pix("dead_no_move", 8'd2, 7'd0, COL_BG);

      // Restart from DEAD
      msm_state = MSM_IDLE;
      step();
      chk("restart_len", {26'd0, length}, 32'd4);
      pix("restart_head", 8'd80, 7'd100, COL_HEAD);
      pix("restart_old", 8'd2, 7'd119, COL_BG);

      // Reversal is rejected
      msm_state = MSM_PLAY;
      step();
      do_tick(DIR_RIGHT);
      step();
      do_tick(DIR_LEFT);
      pix("rev_head", 8'd82, 7'd100, COL_HEAD);
      pix("rev_body", 8'd81, 7'd100, COL_BODY);
      pix("rev_ahead", 8'd83, 7'd100, COL_BG);

      // Grow to full, then capture at saturation
      for (int k = 0; k < 28; k++) begin
         target_x = 8'(83 + k); target_y = 7'd100;
         do_tick(DIR_RIGHT);
         chk("grow_pulse", {31'd0, reached}, 32'd1);
         chk("grow_len", {26'd0, length}, 32'(5 + k));
      end
      chk("full_flag", {31'd0, full}, 32'd1);
      target_x = 8'd111;
      do_tick(DIR_RIGHT);
      chk("sat_pulse", {31'd0, reached}, 32'd1);
      chk("sat_len", {26'd0, length}, 32'd32);
      chk("sat_full", {31'd0, full}, 32'd1);
      pix("sat_tail", 8'd80, 7'd100, COL_BODY);

      // Target rendering
      target_x = 8'd50; target_y = 7'd50;
      pix("tgt_colour", 8'd50, 7'd50, COL_TGT);
      pix("bg_colour", 8'd51, 7'd50, COL_BG);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
